// File: rtl/alarm_clock_core.sv
// Time-of-day counter with programmable alarm, snooze and 12/24-hour display.
// Set, snooze and dismiss are level inputs; only their registered rising edges act.
`timescale 1ns/1ps
module alarm_clock_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       mode_12h_i,
  input  logic       set_hr_i,
  input  logic       set_min_i,
  input  logic       set_alarm_i,
  input  logic       alarm_en_i,
  input  logic       snooze_i,
  input  logic       dismiss_i,
  output logic       tick_o,
  output logic [5:0] sec_o,
  output logic [5:0] min_o,
  output logic [4:0] hr_o,
  output logic [4:0] disp_hr_o,
  output logic       pm_o,
  output logic [4:0] alarm_hr_o,
  output logic [5:0] alarm_min_o,
  output logic       ringing_o,
  output logic       snoozing_o,
  output logic [1:0] state_o
);
  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] PRE_LAST  = CW'(CLK_HZ - 1);
  localparam logic [7:0]    RING_LAST = 8'(RING_SEC - 1);
  localparam logic [6:0]    SNZ_ADD   = 7'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [4:0]    alarm_hr_q, alarm_hr_d, snz_hr_q, snz_hr_d;
  logic [5:0]    alarm_min_q, alarm_min_d, snz_min_q, snz_min_d;
  logic [7:0]    ring_cnt_q, ring_cnt_d;
  logic [3:0]    in_prev_q, edge_q, in_now;
  logic          hr_edge, min_edge, snooze_edge, dismiss_edge;
  logic          tick, time_set, tick_eff, minute_start, alarm_match, snz_match;
  logic [4:0]    hr_inc, tgt_hr;
  logic [5:0]    tgt_min;
  logic [6:0]    snz_sum;

  assign in_now = {dismiss_i, snooze_i, set_min_i, set_hr_i};
  assign {dismiss_edge, snooze_edge, min_edge, hr_edge} = edge_q;

  assign tick     = (cnt_q == PRE_LAST);
  assign time_set = (hr_edge | min_edge) & ~set_alarm_i;
  assign tick_eff = tick & ~time_set;
  assign hr_inc   = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;

  // A time edit wins over a coincident tick; the tick's increment is dropped.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (time_set) begin
      sec_d = '0;
      cnt_d = '0;
      if (hr_edge)  hr_d  = hr_inc;
      if (min_edge) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          hr_d  = hr_inc;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    alarm_hr_d  = alarm_hr_q;
    alarm_min_d = alarm_min_q;
    if (set_alarm_i && hr_edge)
      alarm_hr_d = (alarm_hr_q == 5'd23) ? 5'd0 : alarm_hr_q + 5'd1;
    if (set_alarm_i && min_edge)
      alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
  end

  always_comb begin
    snz_sum = {1'b0, min_q} + SNZ_ADD;
    tgt_hr  = hr_q;
    tgt_min = snz_sum[5:0];
    if (snz_sum >= 7'd60) begin
      tgt_min = 6'(snz_sum - 7'd60);
      tgt_hr  = hr_inc;
    end
  end

  // Matches fire only on a real tick that rolls the seconds over to zero.
  assign minute_start = tick_eff & (sec_q == 6'd59);
  assign alarm_match  = minute_start & (hr_d == alarm_hr_q) & (min_d == alarm_min_q);
  assign snz_match    = minute_start & (hr_d == snz_hr_q) & (min_d == snz_min_q);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_hr_d   = snz_hr_q;
    snz_min_d  = snz_min_q;
    case (state_q)
      ST_IDLE: begin
        if (alarm_en_i && alarm_match) begin
          state_d    = ST_RING;
          ring_cnt_d = '0;
        end
      end
      ST_RING: begin
        if (!alarm_en_i || dismiss_edge) begin
          state_d = ST_IDLE;
        end else if (snooze_edge) begin
          state_d   = ST_SNOOZE;
          snz_hr_d  = tgt_hr;
          snz_min_d = tgt_min;
        end else if (tick_eff) begin
          if (ring_cnt_q == RING_LAST) state_d = ST_IDLE;
          else ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      ST_SNOOZE: begin
        if (!alarm_en_i || dismiss_edge) begin
          state_d = ST_IDLE;
        end else if (snz_match) begin
          state_d    = ST_RING;
          ring_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      alarm_hr_q  <= '0;
      alarm_min_q <= '0;
      snz_hr_q    <= '0;
      snz_min_q   <= '0;
      ring_cnt_q  <= '0;
      in_prev_q   <= '0;
      edge_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      alarm_hr_q  <= alarm_hr_d;
      alarm_min_q <= alarm_min_d;
      snz_hr_q    <= snz_hr_d;
      snz_min_q   <= snz_min_d;
      ring_cnt_q  <= ring_cnt_d;
      in_prev_q   <= in_now;
      edge_q      <= in_now & ~in_prev_q;
    end
  end

  always_comb begin
    disp_hr_o = hr_q;
    if (mode_12h_i) begin
      if (hr_q == 5'd0)       disp_hr_o = 5'd12;
      else if (hr_q > 5'd12)  disp_hr_o = hr_q - 5'd12;
    end
  end

  assign tick_o      = tick;
  assign sec_o       = sec_q;
  assign min_o       = min_q;
  assign hr_o        = hr_q;
  assign pm_o        = (hr_q >= 5'd12);
  assign alarm_hr_o  = alarm_hr_q;
  assign alarm_min_o = alarm_min_q;
  assign ringing_o   = (state_q == ST_RING);
  assign snoozing_o  = (state_q == ST_SNOOZE);
  assign state_o     = state_q;
endmodule

// File: doc/alarm_clock_core.md
# alarm_clock_core

Parametrised time-of-day core with a programmable alarm, snooze and 12/24-hour display mode. It is the successor to the fixed 50 MHz CLOCK counter and sits between the board keys/switches and the BCD/seven-segment display path. The display path consumes `disp_hr`, `min` and `sec` unchanged. The prescaler is parametrised so simulation can run with a tiny `CLK_HZ`.

## Interface
- `CLK_HZ`, 50_000_000, clk cycles per second (≥2)
- `SNOOZE_MIN`, 5, snooze length in minutes (1..59)
- `RING_SEC`, 60, auto-stop ringing after this many seconds (1..255)
- `clk` input 1: the only clock; all state on rising edge
- `rst` input 1: asynchronous, active-low reset
- `mode_12h` input 1: 1 = 12-hour display, 0 = 24-hour display
- `set_hr` input 1: level; each rising edge advances hour by one
- `set_min` input 1: level; each rising edge advances minute by one
- `set_alarm` input 1: 1 = `set_hr`/`set_min` edit the alarm, 0 = edit the time
- `alarm_en` input 1: alarm armed
- `snooze` input 1: level; a rising edge snoozes while ringing
- `dismiss` input 1: level; a rising edge stops ringing or snooze
- `tick` output 1: one-cycle pulse once per second
- `sec` output 6: 0..59
- `min` output 6: 0..59
- `hr` output 5: 0..23, always 24-hour
- `disp_hr` output 5: 1..12 if `mode_12h`, else equal to `hr`
- `pm` output 1: `hr` ≥ 12
- `alarm_hr` output 5: 0..23
- `alarm_min` output 6: 0..59
- `ringing` output 1: alarm active
- `snoozing` output 1: snooze pending

## Operation
- **Reset.** All outputs are 0, except `disp_hr`, which is 12 when `mode_12h`. Prescaler = 0, FSM = IDLE, edge detectors cleared.
- **Prescaler.** Counts 0..`CLK_HZ`-1. `tick` is high in the cycle where count = `CLK_HZ`-1. On that edge `sec` increments.
- **Carry chain.**
  - `sec` 59→0 carries into `min`.
  - `min` 59→0 carries into `hr`.
  - `hr` 23→0 wraps.
- **Set inputs.**
  - Each of `set_hr`, `set_min`, `snooze` and `dismiss` has a registered rising-edge detector (previous-value flop).
  - A set edge with `set_alarm`=0 increments `hr` (mod 24) or `min` (mod 60) with no carry.
  - The same edge clears `sec` and the prescaler.
  - A set edge in the same cycle as a tick takes priority, and the tick's increment is discarded.
  - Simultaneous `set_hr` and `set_min` edges apply both.
  - With `set_alarm`=1, the edge increments `alarm_hr` or `alarm_min` instead. Time keeps running.
- **`disp_hr`.** Combinational: `hr`=0 gives 12; 13..23 gives `hr`-12; otherwise `hr`.
- **Alarm FSM** (states IDLE, RINGING, SNOOZE). The "match event" is the tick edge on which the new time has `sec`=0 and (`hr`,`min`) equal to the target.
  - **IDLE → RINGING:** `alarm_en` and a match event on (`alarm_hr`,`alarm_min`). Clears the ring-second counter.
  - **RINGING → IDLE:** any of the following:
    - `dismiss` edge;
    - `alarm_en`=0;
    - ring-second counter reaches `RING_SEC` (incremented per tick).
  - **RINGING → SNOOZE:** `snooze` edge. Latch the target as current (`hr`,`min`) + `SNOOZE_MIN` minutes, with carry into hours and 24-hour wrap.
  - **SNOOZE → RINGING:** match event on the snooze target. Clears the ring counter.
  - **SNOOZE → IDLE:** `dismiss` edge or `alarm_en`=0.
  - **Priority:** `alarm_en`=0 > `dismiss` > `snooze` > timeout.
  - Time setting never forces a state change. A set that lands exactly on the target does not trigger, because it is not a tick.
- **State outputs.** `ringing` = (state==RINGING). `snoozing` = (state==SNOOZE). Both are registered.

## Timing
- `tick` is high for exactly one cycle every `CLK_HZ` cycles after reset release. The first tick comes `CLK_HZ` cycles after the first active edge.
- `sec`, `min` and `hr` update on the same edge where `tick` is sampled high. They are visible the next cycle with `tick` low.
- A set edge on an input takes effect 1 cycle after the input rises (edge-detect flop), plus the update edge.
- `ringing` rises on the clock edge after the match event and is registered from the FSM.
- An asynchronous `rst` assertion mid-ring clears state immediately, with no clock needed.

## Test plan
- **Count and wrap.** `CLK_HZ`=4. From reset, run 4 cycles: `tick` pulses once and `sec`=1. Preload 23:59:59 via the set inputs and clock: the next tick gives 00:00:00.
- **12-hour mode.** With `mode_12h`=1, step `hr` through 0, 11, 12 and 13: `disp_hr`/`pm` read 12/0, 11/0, 12/1 and 1/1.
- **Set priority.** Pulse `set_min` in the same cycle as `tick` with `min`=59 and `hr`=5: result is `min`=0, `hr`=5, `sec`=0, and the prescaler restarts.
- **Alarm fire and timeout.** Alarm at 06:30, `alarm_en`=1, time 06:29:59, `RING_SEC`=3: `ringing` goes high after the tick to 06:30:00. It drops after 3 more ticks with no input.
- **Snooze wrap.** Ringing at 23:58 with `SNOOZE_MIN`=5, pulse `snooze`: `snoozing`=1. `ringing` reasserts at 00:03:00. A `dismiss` edge then returns to IDLE.
- **Disarm and reset.** While RINGING, drop `alarm_en`: IDLE next cycle. Assert `rst` mid-SNOOZE: all outputs return to reset values asynchronously.
